serial_add_ctrl: RTL and testbench

- Bit-serial adder controller: sequences a single Full_Adder instance over WIDTH cycles to add two WIDTH-bit operands plus carry-in.
- Serves area-constrained datapaths that trade latency for one adder cell.
- Owns operand shift registers, carry flip-flop, bit counter and a start/busy/done handshake.

---
 rtl/serial_add_ctrl_if.sv | 16 +
 rtl/serial_add_ctrl.sv | 98 +++++++++
 tb/tb_serial_add_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: operand/result handshake bundle for the bit-serial adder
//   start/a/b/cin : requester -> adder (request and operands)
//   ready/busy/done/sum/cout : adder -> requester (status and registered result)
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    modport master (output start, a, b, cin, input ready, busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output ready, busy, done, sum, cout);
endinterface

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: adds two WIDTH-bit operands plus carry-in one bit per cycle through a single full adder
//   clk, rst : rising-edge clock, synchronous active-high reset
//   bus      : slave side of serial_add_ctrl_if (start/a/b/cin in; ready/busy/done/sum/cout out)
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_ctrl #(parameter int WIDTH = 8) (
    input logic              clk,
    input logic              rst,
    serial_add_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d, cout_q, cout_d;
    logic             fa_s, fa_co;
    logic [WIDTH-1:0] res_shift;
    logic             last;

    full_adder u_fa (.a(opa_q[0]), .b(opb_q[0]), .cin(carry_q), .s(fa_s), .cout(fa_co));

    // new sum bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts
    assign res_shift = (res_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
    assign last      = cnt_q == CW'(WIDTH - 1);

    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        case (state_q)
            IDLE: if (bus.start) begin
                opa_d   = bus.a;
                opb_d   = bus.b;
                carry_d = bus.cin;
                cnt_d   = '0;
                res_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                opa_d   = opa_q >> 1;
                opb_d   = opb_q >> 1;
                res_d   = res_shift;
                carry_d = fa_co;
                // counter holds at WIDTH-1 on the final bit instead of stepping past it
                if (last) begin
                    sum_d   = res_shift;
                    cout_d  = fa_co;
                    state_d = DONE;
                end else cnt_d = cnt_q + CW'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign bus.ready = state_q == IDLE;
    assign bus.busy  = state_q == RUN;
    assign bus.done  = state_q == DONE;
    assign bus.sum   = sum_q;
    assign bus.cout  = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for serial_add_ctrl at WIDTH=8 and WIDTH=1
module tb_serial_add_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [8:0] q8[$];
    logic [1:0] q1[$];
    logic d8p = 1'b0;
    logic d1p = 1'b0;

    serial_add_ctrl_if #(.WIDTH(8)) if8 ();
    serial_add_ctrl_if #(.WIDTH(1)) if1 ();
    serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
    serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) if (!rst) begin
        chk("onehot8", {if8.ready, if8.busy, if8.done} inside {3'b100, 3'b010, 3'b001}, 1);
        chk("onehot1", {if1.ready, if1.busy, if1.done} inside {3'b100, 3'b010, 3'b001}, 1);
        if (if8.done) begin
            chk("pulse8", d8p, 0);
            chk("spur8", q8.size() != 0, 1);
            if (q8.size() != 0) chk("res8", {if8.cout, if8.sum}, q8.pop_front());
        end
        if (if1.done) begin
            chk("pulse1", d1p, 0);
            chk("spur1", q1.size() != 0, 1);
            if (q1.size() != 0) chk("res1", {if1.cout, if1.sum}, q1.pop_front());
        end
        d8p <= if8.done;
        d1p <= if1.done;
    end

    task automatic start8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int n = 0;
        while (!if8.ready && n < 30) begin @(negedge clk); n++; end
        if (!if8.ready) chk("rdy_to8", if8.ready, 1);
        if8.a = x; if8.b = y; if8.cin = c; if8.start = 1'b1;
        q8.push_back(9'(x) + 9'(y) + 9'(c));
        @(posedge clk); #1 if8.start = 1'b0;
    endtask

    task automatic start1(input logic x, input logic y, input logic c);
        int n = 0;
        while (!if1.ready && n < 30) begin @(negedge clk); n++; end
        if (!if1.ready) chk("rdy_to1", if1.ready, 1);
        if1.a = x; if1.b = y; if1.cin = c; if1.start = 1'b1;
        q1.push_back(2'(x) + 2'(y) + 2'(c));
        @(posedge clk); #1 if1.start = 1'b0;
    endtask

    task automatic wait_done8(output int n, output int nb);
        n = 0; nb = 0;
        do begin @(negedge clk); n++; if (if8.busy) nb++; end while (!if8.done && n < 40);
        if (!if8.done) chk("done_to8", if8.done, 1);
    endtask

    task automatic count_done8(input int cyc, output int nd);
        nd = 0;
        repeat (cyc) begin @(negedge clk); if (if8.done) nd++; end
    endtask

    initial begin
        #500000;
        $display("FAIL global timeout total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        int n, nb, nd, acc, last, rdy_n, c1;
        if8.start = 0; if8.a = 0; if8.b = 0; if8.cin = 0;
        if1.start = 0; if1.a = 0; if1.b = 0; if1.cin = 0;
        repeat (2) @(negedge clk);
        chk("rst_ready", if8.ready, 1);
        chk("rst_busy", if8.busy, 0);
        chk("rst_done", if8.done, 0);
        chk("rst_sum", if8.sum, 0);
        chk("rst_cout", if8.cout, 0);
        @(posedge clk); #1 rst = 1'b0;

        start8(8'h5A, 8'h3C, 0);
        wait_done8(n, nb);
        chk("lat8", n, 9);
        chk("busy8", nb, 8);
        chk("sum_5a3c", if8.sum, 8'h96);
        start8(8'hFF, 8'h01, 0);
        wait_done8(n, nb);
        chk("cout_ff01", if8.cout, 1);
        start8(8'hFF, 8'hFF, 1);
        wait_done8(n, nb);
        chk("sum_ffff1", {if8.cout, if8.sum}, 9'h1FF);

        start8(8'h12, 8'h34, 1);
        repeat (2) @(negedge clk);
        if8.a = 0; if8.b = 0; if8.start = 1'b1;
        @(negedge clk); if8.start = 1'b0;
        @(negedge clk); if8.start = 1'b1;
        @(negedge clk); if8.start = 1'b0;
        count_done8(15, nd);
        chk("ign_done", nd, 1);
        chk("ign_sum", if8.sum, 8'h47);

        if8.a = 8'h01; if8.b = 8'h01; if8.cin = 0;
        while (!if8.ready) @(negedge clk);
        if8.start = 1'b1;
        q8.push_back(9'h002);
        acc = 1; last = -1; rdy_n = 0; nd = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (if8.ready && if8.start) begin
                rdy_n++;
                if (acc < 3) begin q8.push_back(9'h002); acc++; end
                else if8.start = 1'b0;
            end
            if (if8.done) begin
                if (last >= 0) chk("period", c - last, 10);
                last = c; nd++;
            end
        end
        if8.start = 1'b0;
        chk("held_dones", nd, 3);
        chk("held_rdy", rdy_n, 3);

        start8(8'hA5, 8'h5A, 1);
        void'(q8.pop_back());
        repeat (4) @(negedge clk);
        rst = 1'b1; if8.start = 1'b1;
        @(posedge clk); #1 rst = 1'b0; if8.start = 1'b0;
        @(negedge clk);
        chk("abort_ready", if8.ready, 1);
        chk("abort_busy", if8.busy, 0);
        chk("abort_sum", if8.sum, 0);
        chk("abort_cout", if8.cout, 0);
        count_done8(14, nd);
        chk("abort_nodone", nd, 0);
        start8(8'h0F, 8'hF0, 1);
        wait_done8(n, nb);
        chk("post_abort", {if8.cout, if8.sum}, 9'h100);

        start1(1, 1, 1);
        c1 = 0;
        do begin @(negedge clk); c1++; end while (!if1.done && c1 < 10);
        chk("lat1", c1, 2);
        for (int i = 0; i < 1000; i++) start8(8'($urandom), 8'($urandom), 1'($urandom));
        for (int i = 0; i < 1000; i++) start1(1'($urandom), 1'($urandom), 1'($urandom));
        repeat (20) @(negedge clk);
        chk("q8_empty", q8.size(), 0);
        chk("q1_empty", q1.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
